// File: rtl/bram_rd_arbiter.sv
// Round-robin read arbiter sharing one BRAM bank group between REQ_NUM requesters.
// Combinational grant, 3-cycle request-to-data latency, new grant every cycle; hold_i stalls new grants only.
module bram_rd_arbiter #(
    parameter int BANK_NUM        = 4,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int REQ_NUM         = 3
) (
    input  logic                                     clk,
    input  logic                                     rst_p,
    input  logic [REQ_NUM-1:0]                       req_i,
    input  logic [REQ_NUM*BANK_NUM-1:0]              req_bank_en_i,
    input  logic [REQ_NUM*BANK_NUM*BANK_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                                     hold_i,
    output logic [REQ_NUM-1:0]                       gnt_o,
    output logic [BANK_NUM-1:0]                      read_bank_en_o,
    output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]      read_addr_o,
    input  logic [BANK_NUM*BANK_DATA_WIDTH-1:0]      read_data_i,
    output logic [BANK_NUM*BANK_DATA_WIDTH-1:0]      read_data_o,
    output logic [REQ_NUM-1:0]                       rvalid_o,
    output logic                                     busy_o
);

    localparam int PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int SLICE_A = BANK_NUM * BANK_ADDR_WIDTH;

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    win;
    logic                gnt_any;
    logic [REQ_NUM-1:0]  gnt;
    logic [BANK_NUM-1:0] sel_en;
    logic [SLICE_A-1:0]  sel_addr;
    logic [REQ_NUM-1:0]  tag0, tag1, tag2;

    // Scan candidates in priority order starting at ptr; the first requester found wins.
    always_comb begin
        gnt     = '0;
        win     = '0;
        gnt_any = 1'b0;
        if (!rst_p && !hold_i) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                for (int r = 0; r < REQ_NUM; r++) begin
                    if (!gnt_any && req_i[r] && ((int'(ptr) + k) % REQ_NUM) == r) begin
                        gnt_any = 1'b1;
                        gnt[r]  = 1'b1;
                        win     = PTR_W'(r);
                    end
                end
            end
        end
    end

    always_comb begin
        sel_en   = '0;
        sel_addr = '0;
        for (int r = 0; r < REQ_NUM; r++) begin
            if (gnt[r]) begin
                sel_en   = req_bank_en_i[r*BANK_NUM +: BANK_NUM];
                sel_addr = req_addr_i[r*SLICE_A +: SLICE_A];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            ptr            <= '0;
            read_bank_en_o <= '0;
            read_addr_o    <= '0;
            tag0           <= '0;
            tag1           <= '0;
            tag2           <= '0;
        end else begin
            // Tags mirror the BRAM's 2-cycle read latency behind the address register.
            tag0 <= gnt;
            tag1 <= tag0;
            tag2 <= tag1;
            if (gnt_any) begin
                ptr            <= (win == PTR_W'(REQ_NUM - 1)) ? '0 : win + PTR_W'(1);
                read_bank_en_o <= sel_en;
                read_addr_o    <= sel_addr;
            end else begin
                read_bank_en_o <= '0;
            end
        end
    end

    assign gnt_o       = gnt;
    assign rvalid_o    = tag2;
    assign read_data_o = read_data_i;
    assign busy_o      = |{tag0, tag1, tag2, gnt};

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Bench for bram_rd_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_bram_rd_arbiter;

    localparam int N  = 3;
    localparam int B  = 4;
    localparam int AW = 12;
    localparam int DW = 64;

    logic              clk = 1'b0;
    logic              rst_p;
    logic [N-1:0]      req;
    logic [N*B-1:0]    ben;
    logic [N*B*AW-1:0] addr;
    logic              hold;
    logic [N-1:0]      gnt;
    logic [B-1:0]      rd_en;
    logic [B*AW-1:0]   rd_addr;
    logic [B*DW-1:0]   rd_data_in;
    logic [B*DW-1:0]   rd_data;
    logic [N-1:0]      rvalid;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_rd_arbiter #(
        .BANK_NUM(B), .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .REQ_NUM(N)
    ) dut (
        .clk(clk), .rst_p(rst_p), .req_i(req), .req_bank_en_i(ben), .req_addr_i(addr),
        .hold_i(hold), .gnt_o(gnt), .read_bank_en_o(rd_en), .read_addr_o(rd_addr),
        .read_data_i(rd_data_in), .read_data_o(rd_data), .rvalid_o(rvalid), .busy_o(busy)
    );

    function automatic logic [DW-1:0] memf(input int b, input logic [AW-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        return {8'(b + 1), 8'h5A, a16, ~a16, a16 ^ 16'h3C3C};
    endfunction

    // BRAM group: data appears two cycles after the enable is seen.
    logic [B*DW-1:0] s1;
    initial begin
        s1         = '0;
        rd_data_in = '0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < B; b++)
            s1[b*DW +: DW] <= rd_en[b] ? memf(b, rd_addr[b*AW +: AW]) : {DW{1'b1}};
        rd_data_in <= s1;
    end

    // Reference model: outstanding reads kept as a list stamped with their due cycle.
    typedef struct {
        int              due;
        int              r;
        logic [B-1:0]    en;
        logic [B*AW-1:0] a;
    } pend_t;

    pend_t           pend[$];
    pend_t           pe;
    int              m_ptr = 0;
    int              cyc = 0;
    int              mp;
    logic [B-1:0]    m_en = '0;
    logic [B*AW-1:0] m_addr = '0;

    function automatic int m_pick();
        if (rst_p || hold) return -1;
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] v;
        int p;
        v = '0;
        p = m_pick();
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] m_rvalid();
        logic [N-1:0] v;
        v = '0;
        foreach (pend[j]) if (pend[j].due == cyc) v[pend[j].r] = 1'b1;
        return v;
    endfunction

    function automatic logic m_busy();
        return (pend.size() > 0) || (m_pick() >= 0);
    endfunction

    always @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            m_ptr  = 0;
            pend.delete();
            m_en   = '0;
            m_addr = '0;
        end else begin
            mp = m_pick();
            if (mp >= 0) begin
                pe.due = cyc + 3;
                pe.r   = mp;
                pe.en  = ben[mp*B +: B];
                pe.a   = addr[mp*B*AW +: B*AW];
                pend.push_back(pe);
                m_ptr  = (mp + 1) % N;
                m_en   = pe.en;
                m_addr = pe.a;
            end else begin
                m_en = '0;
            end
            cyc++;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_p = 1'b1;
        req   = '0;
        hold  = 1'b0;
        next_cycle();
        rst_p = 1'b0;
    endtask

    task automatic test_reset();
        req = 3'b111;
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b expected 000", rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd_en !== 4'h0) begin errors++; $display("FAIL reset_en: got %h expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", rd_addr); end
        req   = '0;
        rst_p = 1'b0;
    endtask

    task automatic test_single_read();
        logic [B*DW-1:0] exp_d;
        for (int b = 0; b < B; b++) exp_d[b*DW +: DW] = memf(b, 12'h005);
        ben  = '0;
        ben[0 +: B] = 4'hF;
        addr = '0;
        addr[0 +: B*AW] = {B{12'h005}};
        req  = 3'b001;
        hold = 1'b0;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b expected 001", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_t: got %b expected 1", busy); end
        next_cycle();
        req = '0;
        #1;
        checks++; if (rd_en !== 4'hF) begin errors++; $display("FAIL single_en: got %h expected f", rd_en); end
        checks++; if (rd_addr !== {B{12'h005}}) begin errors++; $display("FAIL single_addr: got %h expected %h", rd_addr, {B{12'h005}}); end
        next_cycle();
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL single_rvalid_early: got %b expected 000", rvalid); end
        next_cycle();
        #1;
        checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid: got %b expected 001", rvalid); end
        checks++; if (rd_data !== exp_d) begin errors++; $display("FAIL single_data: got %h expected %h", rd_data, exp_d); end
        next_cycle();
        #1;
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL single_rvalid_after: got %b expected 000", rvalid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        checks++; if (rd_addr !== {B{12'h005}}) begin errors++; $display("FAIL single_addr_hold: got %h expected %h", rd_addr, {B{12'h005}}); end
    endtask

    task automatic test_contention();
        logic [N-1:0] seq [6];
        logic [N-1:0] eg, erv;
        logic [B-1:0] een;
        seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        ben = {4'b0100, 4'b0010, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            req = (i < 6) ? 3'b111 : 3'b000;
            #1;
            eg = '0; erv = '0; een = '0;
            if (i < 6) eg = seq[i];
            if (i >= 3 && i < 9) erv = seq[i-3];
            if (i >= 1 && i < 7) een = 4'(seq[i-1]);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, gnt, eg); end
            checks++; if (rvalid !== erv) begin errors++; $display("FAIL contention_rvalid[%0d]: got %b expected %b", i, rvalid, erv); end
            checks++; if (rd_en !== een) begin errors++; $display("FAIL contention_en[%0d]: got %b expected %b", i, rd_en, een); end
            next_cycle();
        end
    endtask

    task automatic test_hold();
        logic [N-1:0] eg, erv;
        do_reset();
        ben = '1;
        for (int i = 0; i < 9; i++) begin
            req  = (i == 0) ? 3'b001 : ((i <= 5) ? 3'b010 : 3'b000);
            hold = (i >= 1 && i <= 4);
            #1;
            eg  = (i == 0) ? 3'b001 : ((i == 5) ? 3'b010 : 3'b000);
            erv = (i == 3) ? 3'b001 : ((i == 8) ? 3'b010 : 3'b000);
            checks++; if (gnt !== eg) begin errors++; $display("FAIL hold_gnt[%0d]: got %b expected %b", i, gnt, eg); end
            checks++; if (rvalid !== erv) begin errors++; $display("FAIL hold_rvalid[%0d]: got %b expected %b", i, rvalid, erv); end
            next_cycle();
        end
        hold = 1'b0;
    endtask

    task automatic test_midflight_reset();
        do_reset();
        ben = '1;
        req = 3'b100;
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL midrst_gnt: got %b expected 100", gnt); end
        next_cycle();
        rst_p = 1'b1;
        req   = '0;
        #1;
        checks++; if (rd_en !== 4'h0) begin errors++; $display("FAIL midrst_en: got %h expected 0", rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        next_cycle();
        rst_p = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            #1;
            checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid[T+%0d]: got %b expected 000", i, rvalid); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy[T+%0d]: got %b expected 0", i, busy); end
            next_cycle();
        end
    endtask

    task automatic test_zero_enable();
        logic [B*AW-1:0] a2;
        a2 = {12'h0AB, 12'h0CD, 12'h123, 12'hFED};
        do_reset();
        ben = '1;
        ben[2*B +: B] = 4'h0;
        addr[2*B*AW +: B*AW] = a2;
        req = 3'b100;
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL zero_gnt: got %b expected 100", gnt); end
        next_cycle();
        req = '0;
        #1;
        checks++; if (rd_en !== 4'h0) begin errors++; $display("FAIL zero_en: got %h expected 0", rd_en); end
        checks++; if (rd_addr !== a2) begin errors++; $display("FAIL zero_addr: got %h expected %h", rd_addr, a2); end
        next_cycle();
        next_cycle();
        #1;
        checks++; if (rvalid !== 3'b100) begin errors++; $display("FAIL zero_rvalid: got %b expected 100", rvalid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", busy); end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        ben = '1;
        req = 3'b100;
        #1;
        checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wrap_gnt2: got %b expected 100", gnt); end
        next_cycle();
        req = 3'b011;
        #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wrap_gnt0: got %b expected 001", gnt); end
        next_cycle();
        #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wrap_gnt1: got %b expected 010", gnt); end
        next_cycle();
        req = '0;
    endtask

    task automatic test_random();
        logic [B*DW-1:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req  = N'($urandom_range(0, 7));
            hold = ($urandom_range(0, 3) == 0);
            ben  = (N*B)'($urandom);
            for (int k = 0; k < N*B; k++) addr[k*AW +: AW] = AW'($urandom);
            #1;
            checks++; if (gnt !== m_gnt()) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", i, gnt, m_gnt()); end
            checks++; if (rvalid !== m_rvalid()) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", i, rvalid, m_rvalid()); end
            checks++; if (rd_en !== m_en) begin errors++; $display("FAIL rand_en[%0d]: got %b expected %b", i, rd_en, m_en); end
            checks++; if (rd_addr !== m_addr) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, rd_addr, m_addr); end
            checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy[%0d]: got %b expected %b", i, busy, m_busy()); end
            foreach (pend[j]) begin
                if (pend[j].due == cyc) begin
                    for (int b = 0; b < B; b++) begin
                        if (pend[j].en[b]) begin
                            d[b*DW +: DW] = memf(b, pend[j].a[b*AW +: AW]);
                            checks++;
                            if (rd_data[b*DW +: DW] !== d[b*DW +: DW]) begin
                                errors++;
                                $display("FAIL rand_data[%0d] bank %0d: got %h expected %h", i, b, rd_data[b*DW +: DW], d[b*DW +: DW]);
                            end
                        end
                    end
                end
            end
            next_cycle();
        end
        req  = '0;
        hold = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_p = 1'b1;
        req   = '0;
        hold  = 1'b0;
        ben   = '0;
        addr  = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_midflight_reset();
        test_zero_enable();
        test_ptr_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_rd_arbiter.md
BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 SHALL have parameter BANK_NUM, default 4, the number of banks per group.
REQ-002 SHALL have parameter BANK_ADDR_WIDTH, default 12, the per-bank address width.
REQ-003 SHALL have parameter BANK_DATA_WIDTH, default 64, the per-bank data width.
REQ-004 SHALL have parameter REQ_NUM, default 3, the requester count (0=conv, 1=datasaver, 2=misc).
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port rst_p, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_i, input, REQ_NUM bits: per-requester read request.
REQ-008 SHALL have port req_bank_en_i, input, REQ_NUM*BANK_NUM bits: bank enables, slice r for requester r.
REQ-009 SHALL have port req_addr_i, input, REQ_NUM*BANK_NUM*BANK_ADDR_WIDTH bits: addresses, slice r for requester r.
REQ-010 SHALL have port hold_i, input, 1 bit: when high, no new grants are issued.
REQ-011 SHALL have port gnt_o, output, REQ_NUM bits: one-hot grant, combinational, same cycle as the request.
REQ-012 SHALL have port read_bank_en_o, output, BANK_NUM bits: registered bank enables to the bram group.
REQ-013 SHALL have port read_addr_o, output, BANK_NUM*BANK_ADDR_WIDTH bits: registered read addresses to the bram group.
REQ-014 SHALL have port read_data_i, input, BANK_NUM*BANK_DATA_WIDTH bits: bram group read data, valid 2 cycles after enable.
REQ-015 SHALL have port read_data_o, output, BANK_NUM*BANK_DATA_WIDTH bits: read_data_i passed through unregistered.
REQ-016 SHALL have port rvalid_o, output, REQ_NUM bits: one-hot, marks read_data_o as belonging to requester r.
REQ-017 SHALL have port busy_o, output, 1 bit: high while any read is in flight.

Function
REQ-018 SHALL assert gnt_o[r] in cycle T only when req_i[r]=1, hold_i=0 and r is the round-robin winner; at most one bit is set.
REQ-019 SHALL pick the winner as the first requesting index at or after the pointer ptr, wrapping modulo REQ_NUM.
REQ-020 SHALL update ptr at the clock edge ending cycle T to (granted index + 1) mod REQ_NUM; ptr SHALL be unchanged when there is no grant.
REQ-021 SHALL register the granted slice of req_bank_en_i and req_addr_i onto read_bank_en_o and read_addr_o, driving them in cycle T+1.
REQ-022 SHALL drive read_bank_en_o to 0 in any cycle following a non-grant cycle; read_addr_o SHALL hold its last value.
REQ-023 SHALL carry a 3-stage one-hot tag pipeline so that rvalid_o equals the cycle-T grant vector in cycle T+3; total request-to-data latency is 3 cycles.
REQ-024 SHALL accept a new grant every cycle, giving full throughput with no bubbles between back-to-back requests.
REQ-025 SHALL grant a request whose bank_en slice is all zero, issue enb=0, and still pulse rvalid_o at T+3; read_data_o is don't-care in that case.
REQ-026 SHALL block new grants while hold_i=1, while reads already in flight still complete and pulse rvalid_o.
REQ-027 SHALL drive busy_o as the OR of all tag-pipeline stages plus the current-cycle grant.
REQ-028 SHALL let a requester that holds req_i high for several cycles be granted at most once every REQ_NUM cycles while the others are requesting.

Reset
REQ-029 SHALL, on rst_p=1, asynchronously clear ptr to 0, read_bank_en_o to 0, read_addr_o to 0, the tag pipeline to 0, rvalid_o to 0 and busy_o to 0.
REQ-030 SHALL force gnt_o to 0 while rst_p=1.
REQ-031 SHALL drop reads in flight when reset is asserted mid-operation: no rvalid_o pulse after rst_p deasserts.
REQ-032 SHALL allow the first grant in the first cycle after rst_p deasserts.

Verification
REQ-033 SHALL pass the single-read test: req_i=001, bank_en=1111, addr=0x005 each bank (data preloaded) -> gnt_o=001 at T, read_bank_en_o=1111 with addr 0x005 at T+1, rvalid_o=001 with the preloaded data at T+3.
REQ-034 SHALL pass the contention test: req_i=111 held for 6 cycles from reset -> gnt_o sequence 001,010,100,001,010,100, and rvalid_o shows the same sequence delayed by 3 cycles.
REQ-035 SHALL pass the hold test: req_i=010 with hold_i=1 for 4 cycles, then hold_i=0 -> gnt_o=000 for 4 cycles, then 010; an earlier in-flight read still returns rvalid_o.
REQ-036 SHALL pass the mid-flight reset test: a grant at T, rst_p pulsed at T+1 -> rvalid_o stays 000 through T+5 and busy_o=0 after reset.
REQ-037 SHALL pass the zero-enable test: req_i=100 with bank_en=0000 -> gnt_o=100, read_bank_en_o=0000 at T+1, rvalid_o=100 at T+3.
REQ-038 SHALL pass the pointer-wrap test: grant to index 2, then req_i=011 -> next grant to index 0.
